// File: rtl/pwm_capture.sv
// PWM input capture: measures period (rise to rise) and high time in sys_clk cycles.
// Define PWM_CAP_FILTER_EN to insert a FILT_LEN-cycle glitch filter after the synchroniser.
module pwm_capture #(
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             signal_lost,
  output logic             lost_level
);

  if (FILT_LEN < 1) begin : g_bad_filt
    $error("pwm_capture: FILT_LEN must be at least 1");
  end
  if (TIMEOUT < 2 || TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must lie in [2, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  logic sync1_q, sync2_q, pwm_d_q;
  logic pwm_s;
  logic rise, fall;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      pwm_d_q <= pwm_s;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int unsigned  FW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          pwm_f_q, pwm_f_d;

  // Counts consecutive cycles the synced bit disagrees with the filtered level;
  // any agreement restarts the count, so short glitches never propagate.
  always_comb begin
    flt_cnt_d = '0;
    pwm_f_d   = pwm_f_q;
    if (sync2_q != pwm_f_q) begin
      if (flt_cnt_q == FLAST) begin
        pwm_f_d = sync2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      flt_cnt_q <= '0;
      pwm_f_q   <= 1'b0;
    end else begin
      flt_cnt_q <= flt_cnt_d;
      pwm_f_q   <= pwm_f_d;
    end
  end

  assign pwm_s = pwm_f_q;
`else
  assign pwm_s = sync2_q;
`endif

  assign rise = pwm_s & ~pwm_d_q;
  assign fall = ~pwm_s & pwm_d_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;
  logic             lvl_q, lvl_d;
  logic             timeout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? CNT_W'(1) : ((cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1));
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;
    lvl_d    = lvl_q;
    timeout  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_SYNC;
      S_SYNC: if (rise) state_d = S_HIGH;
      S_HIGH: begin
        if (cnt_q == TMO) begin
          timeout = 1'b1;
        end else if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        // A rise landing on the saturation cycle still completes the period.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_lat_q;
          valid_d  = 1'b1;
          lost_d   = 1'b0;
          state_d  = S_HIGH;
        end else if (cnt_q == TMO) begin
          timeout = 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (timeout) begin
      lost_d  = 1'b1;
      lvl_d   = pwm_s;
      state_d = S_SYNC;
    end
  end

  // Reset parks in S_IDLE, which hands over to S_SYNC on the following cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      lvl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      lvl_q    <= lvl_d;
    end
  end

  assign period_cnt  = period_q;
  assign high_cnt    = high_q;
  assign meas_valid  = valid_q;
  assign signal_lost = lost_q;
  assign lost_level  = lvl_q;

endmodule
